// File: rtl/mod3_check_pkg.sv
// mod3_check_pkg
//   Shared types and the residue step function for the divide-by-3 checker.
//   sched_state_t : scheduler FSM states (IDLE, SHIFT, RESP)
//   residue_t     : 2-bit residue; the encoding 2'd3 is never produced
//   next_residue  : one MSB-first step, r' = (2r + b) mod 3
package mod3_check_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } sched_state_t;

    typedef enum logic [1:0] {
        REM0 = 2'd0,
        REM1 = 2'd1,
        REM2 = 2'd2
    } residue_t;

    function automatic residue_t next_residue(residue_t r, logic b);
        residue_t n;
        case (r)
            REM0:    n = b ? REM1 : REM0;
            REM1:    n = b ? REM0 : REM2;
            REM2:    n = b ? REM2 : REM1;
            default: n = REM0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mod3_serial_core.sv
// mod3_serial_core
//   Bit-serial mod-3 residue accumulator, bits presented MSB first.
//   clk     in  clock, rising edge
//   rst_n   in  synchronous active-low reset, clears residue
//   clr     in  clear residue to 0 (takes priority over bit_vld)
//   bit_vld in  consume bit_in this cycle
//   bit_in  in  next data bit
//   rem     out current residue
module mod3_serial_core
    import mod3_check_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     clr,
    input  logic     bit_vld,
    input  logic     bit_in,
    output residue_t rem
);

    residue_t rem_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q <= REM0;
        end else if (clr) begin
            rem_q <= REM0;
        end else if (bit_vld) begin
            rem_q <= next_residue(rem_q, bit_in);
        end
    end

    assign rem = rem_q;

endmodule

// File: rtl/mod3_check_sched.sv
// mod3_check_sched
//   Shares one serial mod-3 engine among NUM_REQ requesters. A winner is
//   picked round-robin (or fixed-priority when MOD3_FIXED_PRIO_EN is
//   defined), its word is shifted MSB-first through the engine, and the
//   remainder / divisible flag / owner ID come back on one response channel.
//
//   Build option: `define MOD3_FIXED_PRIO_EN -> lowest asserted index wins,
//   no round-robin pointer. Default build is round-robin.
//
//   Ports
//   i_clk        in   clock, rising edge
//   i_rst_n      in   synchronous active-low reset
//   i_req_valid  in   [NUM_REQ]         per-requester valid
//   o_req_ready  out  [NUM_REQ]         one-hot accept (IDLE only)
//   i_req_data   in   [NUM_REQ*DATA_W]  requester k at [k*DATA_W +: DATA_W]
//   o_rsp_valid  out  response valid
//   i_rsp_ready  in   response accept
//   o_rsp_id     out  [ID_W] owning requester
//   o_rsp_rem    out  [2] word mod 3
//   o_rsp_div3   out  word divisible by 3
//   o_busy       out  high in SHIFT or RESP
//
//   state | meaning
//   IDLE  | arbitrating; o_req_ready shows the winner combinationally
//   SHIFT | feeding DATA_W bits, one per cycle, into the residue core
//   RESP  | response held until i_rsp_ready
module mod3_check_sched
    import mod3_check_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 8,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [ID_W-1:0]           o_rsp_id,
    output logic [1:0]                o_rsp_rem,
    output logic                      o_rsp_div3,
    output logic                      o_busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    sched_state_t        state_q, state_d;
    logic [ID_W-1:0]     id_q;
    logic [DATA_W-1:0]   shreg_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     win_id;
    logic                win_vld;
    logic                accept;
    logic                shift_en;
    residue_t            rem;

`ifdef MOD3_FIXED_PRIO_EN
    // Scan from the top so the lowest asserted index is the last writer.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req_valid[i]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0] ptr_q;

    // Search from ptr_q upward; the wrap is done by subtraction so a
    // non-power-of-two NUM_REQ still walks only legal indices.
    always_comb begin
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] cand;
        win_vld = 1'b0;
        win_id  = '0;
        sum     = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            cand = sum[ID_W-1:0];
            if (!win_vld && i_req_valid[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ptr_q <= '0;
        end else if (accept) begin
            ptr_q <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
        end
    end
`endif

    assign grant = win_vld ? (NUM_REQ'(1) << win_id) : '0;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_vld) state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_W'(DATA_W - 1)) state_d = RESP;
            RESP:    if (i_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs; response fields are forced to 0 outside RESP so a stale
    // residue never shows up as a spurious div3.
    always_comb begin
        accept      = (state_q == IDLE) && win_vld;
        shift_en    = (state_q == SHIFT);
        o_req_ready = (state_q == IDLE) ? grant : '0;
        o_rsp_valid = (state_q == RESP);
        o_busy      = (state_q != IDLE);
        o_rsp_id    = o_rsp_valid ? id_q : '0;
        o_rsp_rem   = o_rsp_valid ? rem : 2'd0;
        o_rsp_div3  = o_rsp_valid && (rem == REM0);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            id_q    <= '0;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            id_q    <= win_id;
            shreg_q <= i_req_data[int'(win_id)*DATA_W +: DATA_W];
            cnt_q   <= '0;
        end else if (shift_en) begin
            shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    mod3_serial_core u_core (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .clr     (accept),
        .bit_vld (shift_en),
        .bit_in  (shreg_q[DATA_W-1]),
        .rem     (rem)
    );

endmodule

// File: doc/mod3_check_sched.md
Name: mod3_check_sched

Overview:
- Shares one bit-serial divide-by-3 residue engine among NUM_REQ requesters.
- Each requester offers a DATA_W-bit word through a valid/ready handshake. The scheduler grants one requester round-robin and shifts the word MSB-first through the residue engine.
- It returns the remainder, a divisible-by-3 flag and the requester ID on a single response channel with backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_W, 8, word width in bits (≥2).
- ID_W, $clog2(NUM_REQ), localparam, response ID width.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_req_valid  in  NUM_REQ  per-requester word valid.
- o_req_ready  out  NUM_REQ  one-hot accept; at most one bit set.
- i_req_data  in  NUM_REQ*DATA_W  packed words; requester k at bits [k*DATA_W +: DATA_W].
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response accept.
- o_rsp_id  out  ID_W  index of the requester that owns the response.
- o_rsp_rem  out  2  word mod 3, values 0..2.
- o_rsp_div3  out  1  1 when o_rsp_rem==0.
- o_busy  out  1  high in SHIFT or RESP.

Behaviour:
- Reset (i_rst_n==0 at a clock edge):
  - State goes to IDLE.
  - o_rsp_valid, o_rsp_id, o_rsp_rem, o_rsp_div3 and o_busy all go to 0.
  - Round-robin pointer is set so requester 0 has top priority.
  - Shift register and residue are cleared.
  - Reset mid-operation drops the in-flight word with no response.
- FSM states IDLE, SHIFT, RESP:
  - IDLE: o_req_ready is combinational. It is the one-hot RR winner among asserted i_req_valid, searching from pointer upward with wrap-around, and is 0 when no request is valid. On valid&ready in cycle A:
    - Capture the word and the winner ID.
    - Clear the residue.
    - Set pointer to winner+1 mod NUM_REQ.
    - Go to SHIFT.
  - SHIFT: exactly DATA_W cycles (A+1..A+DATA_W). Each cycle consumes the MSB: r <= (2r+bit) mod 3. The word is shifted left. A bit counter goes 0..DATA_W-1. After the last bit, go to RESP. o_req_ready is all-zero.
  - RESP: o_rsp_valid=1 starting cycle A+DATA_W+1. o_rsp_id, o_rsp_rem and o_rsp_div3 hold stable while valid and !i_rsp_ready. On o_rsp_valid&i_rsp_ready in cycle B, o_rsp_valid drops and the state returns to IDLE at B+1. The next accept is possible in cycle B+1.
- Timing:
  - Latency from accept to response valid is DATA_W+1 cycles.
  - Minimum period is DATA_W+2 cycles per word.
- Requester rules:
  - Requesters must hold valid and data until ready.
  - Valid must not depend on ready.
  - A requester dropping valid before grant is legal; it is simply not selected.
- Residue transition table: 0→(0,1), 1→(2,0), 2→(1,2) for bit (0,1).
- Width rules:
  - The residue is always 2 bits; value 3 is never produced.
  - The bit counter is $clog2(DATA_W+1) bits, so the counter cannot overflow at DATA_W.

Optional Feature:
- Macro: MOD3_FIXED_PRIO_EN.
- Defined: the arbiter is fixed-priority; the lowest asserted index always wins, and the pointer is not used.
- Undefined (default): round-robin as described above.
- The response path is identical in both builds.

Decomposition:
- Package mod3_check_pkg holds:
  - sched_state_t enum {IDLE, SHIFT, RESP}.
  - residue_t enum {REM0=2'd0, REM1=2'd1, REM2=2'd2}.
  - Function next_residue(residue_t r, logic b).
- Sub-module mod3_serial_core: inputs clk, rst_n, clr, bit_vld, bit_in; output residue_t rem. The scheduler instantiates one.

Test Plan:
- Req0 valid, data 8'd9, i_rsp_ready=1 → accepted cycle A; rsp_valid at A+9 with id 0, rem 0, div3 1.
- Single requests with data 8'd7, 8'd200, 8'hFF → rem 1/div3 0, rem 2/div3 0, rem 0/div3 1 respectively.
- All 4 requesters valid continuously → grant order 0,1,2,3,0,1; with MOD3_FIXED_PRIO_EN defined the order is 0,0,0.
- Response with i_rsp_ready low 5 cycles → id, rem and div3 held stable; o_req_ready stays 0; next grant is the cycle after the handshake.
- Reset asserted mid-SHIFT (cycle A+4) → next cycle o_busy 0, o_rsp_valid 0; no response ever emitted for that word; next grant goes to req0.
- Req2 valid alone after a grant to req3 → pointer wraps to 0; req2 is granted; rsp id 2.
